// File: rtl/board_sequencer.sv
// Connect-Four board owner: validates column drops, animates the falling piece on frame
// ticks, commits it, alternates players and serves a registered cell read port.
module board_sequencer #(
  parameter int unsigned ROWS       = 6,
  parameter int unsigned COLS       = 7,
  parameter int unsigned DROP_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [2:0] move_col,
  output logic       move_ready,
  output logic       move_done,
  output logic       move_reject,
  output logic [1:0] cur_player,
  output logic       anim_active,
  output logic       board_full,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [1:0] rd_state
);

  localparam int unsigned TW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCheck = 3'd1;
  localparam logic [2:0] StDrop  = 3'd2;
  localparam logic [2:0] StPlace = 3'd3;
  localparam logic [2:0] StFull  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [1:0]    cell_q [ROWS][COLS];
  logic [2:0]    height_q [COLS];
  logic [5:0]    placed_q;
  logic [2:0]    lat_col_q;
  logic [2:0]    tgt_row_q;
  logic [2:0]    fall_row_q;
  logic [TW-1:0] tick_cnt_q;
  logic [1:0]    cur_player_q;
  logic [1:0]    rd_state_q, rd_state_d;
  logic          move_done_q;
  logic          move_reject_q;

  logic illegal;
  logic step_done;
  logic last_piece;

  always_comb begin
    illegal = 1'b0;
    if (32'(lat_col_q) >= COLS) begin
      illegal = 1'b1;
    end else if (32'(height_q[lat_col_q]) >= ROWS) begin
      illegal = 1'b1;
    end
  end

  assign step_done  = frame_tick && (32'(tick_cnt_q) == DROP_TICKS - 1);
  assign last_piece = (32'(placed_q) + 32'd1) == ROWS * COLS;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (move_valid) state_d = StCheck;
      StCheck: state_d = illegal ? StIdle : StDrop;
      StDrop:  if (step_done && (fall_row_q == tgt_row_q)) state_d = StPlace;
      StPlace: state_d = last_piece ? StFull : StIdle;
      StFull:  state_d = StFull;
      default: state_d = StIdle;
    endcase
    if (new_game) state_d = StIdle;
  end

  // The falling piece is overlaid on the read port so the renderer needs no extra logic.
  always_comb begin
    rd_state_d = 2'd0;
    if ((32'(rd_row) < ROWS) && (32'(rd_col) < COLS)) begin
      if ((state_q == StDrop) && (rd_row == fall_row_q) && (rd_col == lat_col_q)) begin
        rd_state_d = cur_player_q;
      end else begin
        rd_state_d = cell_q[rd_row][rd_col];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cell_q        <= '{default: '{default: 2'b00}};
      height_q      <= '{default: 3'd0};
      placed_q      <= 6'd0;
      lat_col_q     <= 3'd0;
      tgt_row_q     <= 3'd0;
      fall_row_q    <= 3'd0;
      tick_cnt_q    <= '0;
      cur_player_q  <= 2'd1;
      rd_state_q    <= 2'd0;
      move_done_q   <= 1'b0;
      move_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_state_q    <= rd_state_d;
      move_done_q   <= 1'b0;
      move_reject_q <= 1'b0;
      if (new_game) begin
        cell_q       <= '{default: '{default: 2'b00}};
        height_q     <= '{default: 3'd0};
        placed_q     <= 6'd0;
        tick_cnt_q   <= '0;
        fall_row_q   <= 3'd0;
        cur_player_q <= 2'd1;
        rd_state_q   <= 2'd0;
      end else begin
        case (state_q)
          StIdle: begin
            if (move_valid) lat_col_q <= move_col;
          end
          StCheck: begin
            if (illegal) begin
              move_reject_q <= 1'b1;
            end else begin
              tgt_row_q  <= 3'(ROWS - 1) - height_q[lat_col_q];
              fall_row_q <= 3'd0;
              tick_cnt_q <= '0;
            end
          end
          StDrop: begin
            if (frame_tick) begin
              if (step_done) begin
                tick_cnt_q <= '0;
                if (fall_row_q != tgt_row_q) fall_row_q <= fall_row_q + 3'd1;
              end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
              end
            end
          end
          StPlace: begin
            cell_q[tgt_row_q][lat_col_q] <= cur_player_q;
            height_q[lat_col_q]          <= height_q[lat_col_q] + 3'd1;
            placed_q                     <= placed_q + 6'd1;
            move_done_q                  <= 1'b1;
            cur_player_q                 <= (cur_player_q == 2'd1) ? 2'd2 : 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign move_ready  = (state_q == StIdle);
  assign anim_active = (state_q == StDrop);
  assign board_full  = (state_q == StFull);
  assign move_done   = move_done_q;
  assign move_reject = move_reject_q;
  assign cur_player  = cur_player_q;
  assign rd_state    = rd_state_q;

  a_done_reject_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(move_done && move_reject));
  a_player_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (cur_player == 2'd1) || (cur_player == 2'd2));

endmodule

// File: tb/tb_board_sequencer.sv
// Randomized scoreboard bench for board_sequencer: a board model predicts each move's
// outcome, a monitor pops predictions as the DUT reports done/reject.
module tb_board_sequencer;
  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int DT   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       new_game = 1'b0;
  logic       move_valid = 1'b0;
  logic [2:0] move_col = 3'd0;
  logic [2:0] rd_row = 3'd0;
  logic [2:0] rd_col = 3'd0;
  logic       move_ready, move_done, move_reject, anim_active, board_full;
  logic [1:0] cur_player, rd_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit is_done;
    int ticks;
    int player_after;
  } exp_t;
  exp_t sb[$];

  int mb [ROWS][COLS];
  int mh [COLS];
  int mplayer;
  int mplaced;
  bit tick_auto = 1'b0;
  bit anim_seen = 1'b0;
  bit prev_anim = 1'b0;
  bit prev_done = 1'b0;
  bit prev_rej  = 1'b0;
  int mon_ticks = 0;

  always #5 clk = ~clk;

  board_sequencer #(.ROWS(ROWS), .COLS(COLS), .DROP_TICKS(DT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_col   (move_col),
    .move_ready (move_ready),
    .move_done  (move_done),
    .move_reject(move_reject),
    .cur_player (cur_player),
    .anim_active(anim_active),
    .board_full (board_full),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_state   (rd_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) mb[r][c] = 0;
    for (int c = 0; c < COLS; c++) mh[c] = 0;
    mplayer = 1;
    mplaced = 0;
  endtask

  // Free-running random frame ticks, driven just after the rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (tick_auto) frame_tick = ($urandom_range(0, 2) == 0);
  end

  // Monitor: sampled on the falling edge, pops one prediction per reported outcome.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      prev_anim = 1'b0;
      prev_done = 1'b0;
      prev_rej  = 1'b0;
      mon_ticks = 0;
    end else begin
      if (anim_active) anim_seen = 1'b1;
      if (anim_active && !prev_anim) mon_ticks = 0;
      if (anim_active && frame_tick) mon_ticks++;
      prev_anim = anim_active;
      if (move_done || move_reject) begin
        check("done_reject_exclusive", {31'd0, move_done && move_reject}, 0);
        check("pulse_width", {31'd0, (move_done && prev_done) || (move_reject && prev_rej)}, 0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_response: done=%b reject=%b, expected none",
                   move_done, move_reject);
        end else begin
          e = sb.pop_front();
          check("resp_kind_done", {31'd0, move_done}, {31'd0, e.is_done});
          check("player_after", {30'd0, cur_player}, e.player_after);
          if (e.is_done) check("fall_ticks", mon_ticks, e.ticks);
        end
      end
      prev_done = move_done;
      prev_rej  = move_reject;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (move_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (move_ready !== 1'b1) fail_now("wait_ready");
  endtask

  task automatic wait_all();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail_now("wait_response");
    @(negedge clk);
  endtask

  task automatic wait_anim();
    int n = 0;
    @(negedge clk);
    while (anim_active !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (anim_active !== 1'b1) fail_now("wait_anim");
  endtask

  task automatic issue_move(input int col);
    exp_t e;
    int   row;
    wait_ready();
    if (col >= COLS || mh[col] == ROWS) begin
      e.is_done      = 1'b0;
      e.ticks        = 0;
      e.player_after = mplayer;
    end else begin
      row          = ROWS - 1 - mh[col];
      mb[row][col] = mplayer;
      mh[col]++;
      mplaced++;
      mplayer        = 3 - mplayer;
      e.is_done      = 1'b1;
      e.ticks        = (row + 1) * DT;
      e.player_after = mplayer;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    move_valid = 1'b1;
    move_col   = col[2:0];
    @(posedge clk);
    #1;
    move_valid = 1'b0;
  endtask

  task automatic read_cell(input int r, input int c, output logic [1:0] v);
    @(posedge clk);
    #1;
    rd_row = r[2:0];
    rd_col = c[2:0];
    @(posedge clk);
    @(negedge clk);
    v = rd_state;
  endtask

  task automatic pulse_new_game();
    @(posedge clk);
    #1 new_game = 1'b1;
    @(posedge clk);
    #1 new_game = 1'b0;
    model_clear();
  endtask

  task automatic manual_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 frame_tick = 1'b1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
    end
  endtask

  initial begin
    logic [1:0] v;
    int         p;
    int         guard;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_anim", {31'd0, anim_active}, 0);
    check("rst_done", {31'd0, move_done}, 0);
    check("rst_reject", {31'd0, move_reject}, 0);
    check("rst_full", {31'd0, board_full}, 0);
    check("rst_player", {30'd0, cur_player}, 1);
    check("rst_rd", {30'd0, rd_state}, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, move_ready}, 1);

    // First drop to col 3, read latency
    tick_auto = 1'b1;
    issue_move(3);
    wait_all();
    check("t1_player", {30'd0, cur_player}, 2);
    read_cell(0, 0, v);
    check("t1_rd_00", {30'd0, v}, 0);
    @(posedge clk);
    #1 rd_row = 3'd5;
    rd_col = 3'd3;
    @(negedge clk);
    check("t1_rd_latency_old", {30'd0, rd_state}, 0);
    @(negedge clk);
    check("t1_rd_53", {30'd0, rd_state}, 1);

    // Column fill then overflow
    pulse_new_game();
    @(negedge clk);
    check("ng_player", {30'd0, cur_player}, 1);
    repeat (6) issue_move(0);
    issue_move(0);
    wait_all();
    check("fill_player", {30'd0, cur_player}, 1);
    for (int r = ROWS - 1; r >= 0; r--) begin
      read_cell(r, 0, v);
      check("fill_cell", {30'd0, v}, ((ROWS - 1 - r) % 2 == 0) ? 1 : 2);
      check("fill_model", {30'd0, v}, mb[r][0]);
    end

    // Illegal column
    anim_seen = 1'b0;
    issue_move(7);
    wait_all();
    check("illegal_no_anim", {31'd0, anim_seen}, 0);
    check("illegal_player", {30'd0, cur_player}, 1);

    // Overlay with hand-paced ticks
    pulse_new_game();
    tick_auto = 1'b0;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    p = mplayer;
    issue_move(2);
    wait_anim();
    read_cell(6, 2, v);
    check("ovl_out_of_range", {30'd0, v}, 0);
    for (int k = 0; k < ROWS; k++) begin
      read_cell(k, 2, v);
      check("ovl_fall_row", {30'd0, v}, p);
      if (k < ROWS - 1) begin
        read_cell(ROWS - 1, 2, v);
        check("ovl_target_empty", {30'd0, v}, 0);
        if (k > 0) begin
          read_cell(k - 1, 2, v);
          check("ovl_above_empty", {30'd0, v}, 0);
        end
      end
      manual_ticks(DT);
    end
    wait_all();
    read_cell(ROWS - 1, 2, v);
    check("ovl_committed", {30'd0, v}, p);

    // Random play to a full board
    tick_auto = 1'b1;
    pulse_new_game();
    guard = 0;
    while (mplaced < ROWS * COLS && guard < 600) begin
      issue_move($urandom_range(0, 7));
      guard++;
    end
    wait_all();
    check("full_flag", {31'd0, board_full}, 1);
    check("full_ready", {31'd0, move_ready}, 0);
    @(posedge clk);
    #1 move_valid = 1'b1;
    move_col = 3'($urandom_range(0, 6));
    repeat (6) @(posedge clk);
    #1 move_valid = 1'b0;
    @(negedge clk);
    check("full_ignored", {31'd0, board_full}, 1);
    check("full_anim", {31'd0, anim_active}, 0);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        read_cell(r, c, v);
        check("full_cell", {30'd0, v}, mb[r][c]);
      end
    end
    pulse_new_game();
    @(negedge clk);
    check("clr_player", {30'd0, cur_player}, 1);
    check("clr_ready", {31'd0, move_ready}, 1);
    check("clr_full", {31'd0, board_full}, 0);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        read_cell(r, c, v);
        check("clr_cell", {30'd0, v}, 0);
      end
    end

    // new_game mid-drop
    issue_move(6);
    wait_all();
    tick_auto = 1'b0;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    issue_move(4);
    wait_anim();
    manual_ticks(1);
    @(posedge clk);
    #1 new_game = 1'b1;
    @(negedge clk);
    check("abort_anim_before", {31'd0, anim_active}, 1);
    @(posedge clk);
    #1 new_game = 1'b0;
    void'(sb.pop_back());
    model_clear();
    @(negedge clk);
    check("abort_anim_after", {31'd0, anim_active}, 0);
    check("abort_ready", {31'd0, move_ready}, 1);
    check("abort_player", {30'd0, cur_player}, 1);
    tick_auto = 1'b1;
    repeat (40) @(negedge clk);
    read_cell(ROWS - 1, 4, v);
    check("abort_target", {30'd0, v}, 0);
    read_cell(ROWS - 1, 6, v);
    check("abort_prev_cleared", {30'd0, v}, 0);

    // Async reset mid-drop
    issue_move(5);
    wait_all();
    tick_auto = 1'b0;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    issue_move(5);
    wait_anim();
    #1 rst_n = 1'b0;
    #1;
    check("arst_anim", {31'd0, anim_active}, 0);
    check("arst_ready", {31'd0, move_ready}, 1);
    check("arst_player", {30'd0, cur_player}, 1);
    check("arst_rd", {30'd0, rd_state}, 0);
    check("arst_done", {31'd0, move_done}, 0);
    void'(sb.pop_back());
    model_clear();
    @(negedge clk);
    #1 rst_n = 1'b1;
    read_cell(ROWS - 1, 5, v);
    check("arst_cell", {30'd0, v}, 0);
    read_cell(ROWS - 2, 5, v);
    check("arst_cell2", {30'd0, v}, 0);

    // A final move after reset behaves normally
    tick_auto = 1'b1;
    issue_move(5);
    wait_all();
    read_cell(ROWS - 1, 5, v);
    check("post_rst_move", {30'd0, v}, 1);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
